// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto one shared memory slave port, with a wait-cycle timeout.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; otherwise the data port wins every tie.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_sel,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        stall_i,
    output logic        stall_d,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       tie_to_d;
    logic       pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    // Last-grant flag: 0 = fetch port granted last, 1 = data port granted last.
    logic last_d, last_d_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b0;
        end else begin
            last_d <= last_d_nxt;
        end
    end

    always_comb begin
        last_d_nxt = last_d;
        if (state == IDLE && (i_req || d_req)) begin
            last_d_nxt = pick_d;
        end
    end

    assign tie_to_d = !last_d;
`else
    assign tie_to_d = 1'b1;
`endif

    assign pick_d = d_req && (!i_req || tie_to_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        m_req        = 1'b0;
        m_we         = 1'b0;
        m_sel        = '0;
        m_addr       = '0;
        m_wdata      = '0;
        i_ack        = 1'b0;
        i_rdata      = '0;
        d_ack        = 1'b0;
        d_rdata      = '0;
        bus_err      = 1'b0;

        case (state)
            IDLE: begin
                // Counter is cleared here so every grant starts counting from zero.
                wait_cnt_nxt = '0;
                if (pick_d) begin
                    state_nxt = GNT_D;
                end else if (i_req) begin
                    state_nxt = GNT_I;
                end
            end

            GNT_I: begin
                m_req  = 1'b1;
                m_addr = i_addr;
                m_sel  = 4'hF;
                if (m_ack) begin
                    i_ack     = 1'b1;
                    i_rdata   = m_rdata;
                    state_nxt = IDLE;
                end else if (wait_cnt == TIMEOUT_LIM) begin
                    i_ack     = 1'b1;
                    bus_err   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end

            GNT_D: begin
                m_req   = 1'b1;
                m_we    = d_we;
                m_sel   = d_sel;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                if (m_ack) begin
                    d_ack     = 1'b1;
                    d_rdata   = m_rdata;
                    state_nxt = IDLE;
                end else if (wait_cnt == TIMEOUT_LIM) begin
                    d_ack     = 1'b1;
                    bus_err   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Gated by rst so that every output reads 0 while reset is held, even with requests pending.
    assign stall_i = rst & i_req & ~i_ack;
    assign stall_d = rst & d_req & ~d_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transfers push expected acks; a monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int TO = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_sel = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;
    logic        stall_i;
    logic        stall_d;
    logic        bus_err;

    mem_bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_sel   (d_sel),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_sel   (m_sel),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .stall_i (stall_i),
        .stall_d (stall_d),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        slave_en = 1'b1;
    logic        slave_echo = 1'b0;
    int          slave_lat = 1;
    logic [31:0] slave_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic is_d, input logic [31:0] rdata, input logic err);
        resp_t r;
        r.is_d  = is_d;
        r.rdata = rdata;
        r.err   = err;
        exp_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #2;
    endtask

    task automatic reset_check(input string name);
        rst   = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        look();
        chk(name, {m_req, m_we, m_sel, m_addr, i_ack, d_ack, stall_i, stall_d, bus_err}, '0);
        chk({name, "_rdata"}, {i_rdata, d_rdata}, '0);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Slave model: acks after slave_lat cycles of m_req; echo mode returns address-derived data.
    initial begin
        int seen;
        seen = 0;
        forever begin
            @(negedge clk);
            if (m_req) begin
                m_ack = slave_en && (seen == slave_lat);
                seen++;
            end else begin
                seen  = 0;
                m_ack = 1'b0;
            end
            m_rdata = slave_echo ? (m_addr ^ 32'hFFFF_0000) : slave_data;
        end
    end

    // Monitor: every ack cycle pops one expected response.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (i_ack || d_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", {d_ack, i_ack}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_resp", {d_ack, i_ack, (d_ack ? d_rdata : i_rdata), bus_err},
                        {e.is_d, !e.is_d, e.rdata, e.err});
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no completion, expected finish before 50000ns");
        $fatal(1);
    end

    initial begin
        int acks;
        int hit;

        reset_check("reset_outputs");
        look();
        chk("idle_after_reset", {m_req, stall_i, stall_d}, 3'b000);

        // Single fetch, with junk on the idle data port that must not leak.
        tick();
        i_req = 1'b1; i_addr = 32'h0000_0040;
        d_we = 1'b1; d_sel = 4'h5; d_wdata = 32'hDEAD_0000;
        slave_data = 32'h3401_0011; slave_lat = 1;
        expect_resp(1'b0, 32'h3401_0011, 1'b0);
        look();
        chk("fetch_pending", {m_req, stall_i}, 2'b01);
        look();
        chk("fetch_grant_ctl", {m_req, m_we, m_sel, stall_i}, {1'b1, 1'b0, 4'hF, 1'b1});
        chk("fetch_grant_addr", m_addr, 32'h0000_0040);
        chk("fetch_grant_wdata", m_wdata, 32'h0);
        look();
        chk("fetch_ack", {i_ack, stall_i, d_ack, d_rdata}, {1'b1, 1'b0, 1'b0, 32'h0});
        tick();
        i_req = 1'b0;
        look();
        chk("fetch_idle", {m_req, i_ack, m_we, m_sel, m_addr, m_wdata}, '0);

        // Data write.
        tick();
        d_req = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'h0000_0100; d_wdata = 32'h0000_ABCD;
        slave_data = 32'h1111_2222;
        expect_resp(1'b1, 32'h1111_2222, 1'b0);
        look();
        chk("write_pending", {m_req, stall_d}, 2'b01);
        look();
        chk("write_grant_ctl", {m_req, m_we, m_sel, stall_d}, {1'b1, 1'b1, 4'b0011, 1'b1});
        chk("write_grant_addr", m_addr, 32'h0000_0100);
        chk("write_grant_wdata", m_wdata, 32'h0000_ABCD);
        look();
        chk("write_ack", {d_ack, stall_d, i_ack, i_rdata}, {1'b1, 1'b0, 1'b0, 32'h0});
        tick();
        d_req = 1'b0;
        look();
        chk("write_idle", {m_req, m_we, m_sel, m_wdata}, '0);

        // Request dropped while granted: transfer still completes, no new grant.
        tick();
        d_we = 1'b0; d_sel = 4'hF; d_wdata = '0; d_addr = 32'h0000_0400;
        d_req = 1'b1; slave_lat = 3; slave_data = 32'h5555_AAAA;
        expect_resp(1'b1, 32'h5555_AAAA, 1'b0);
        look();
        look();
        chk("drop_grant", m_req, 1'b1);
        tick();
        d_req = 1'b0;
        look();
        chk("drop_hold_c1", {m_req, stall_d, d_ack}, 3'b100);
        look();
        chk("drop_hold_c2", {m_req, m_addr}, {1'b1, 32'h0000_0400});
        look();
        chk("drop_ack", {m_req, d_ack}, 2'b11);
        look();
        chk("drop_idle", m_req, 1'b0);
        look();
        chk("drop_no_regrant", m_req, 1'b0);

        // Timeout: slave never acks.
        tick();
        slave_en = 1'b0; slave_lat = 1;
        d_req = 1'b1; d_addr = 32'h0000_0500;
        expect_resp(1'b1, 32'h0, 1'b1);
        look();
        look();
        chk("to_grant", {m_req, bus_err}, 2'b10);
        hit = -1;
        for (int k = 1; k <= TO + 3 && hit < 0; k++) begin
            look();
            if (bus_err) begin
                hit = k;
                chk("to_ack", {d_ack, d_rdata}, {1'b1, 32'h0});
            end
        end
        chk("to_cycle", hit, TO);
        tick();
        d_req = 1'b0;
        look();
        chk("to_idle", {m_req, bus_err, d_ack}, 3'b000);
        slave_en = 1'b1;

        // Reset asserted mid-transfer abandons it; fetch re-granted after release.
        tick();
        i_req = 1'b1; i_addr = 32'h0000_0080; slave_lat = 3; slave_data = 32'h7777_0080;
        look();
        look();
        chk("rmt_grant", {m_req, m_addr}, {1'b1, 32'h0000_0080});
        rst = 1'b0;
        d_req = 1'b1;
        #1;
        chk("rmt_abort", {m_req, i_ack, d_ack, bus_err, stall_i, stall_d}, 6'b0);
        look();
        chk("rmt_hold", {m_req, i_ack, d_ack, stall_i, stall_d, m_addr}, '0);
        d_req = 1'b0;
        tick();
        rst = 1'b1; slave_lat = 1;
        expect_resp(1'b0, 32'h7777_0080, 1'b0);
        look();
        chk("rmt_release", {m_req, stall_i}, 2'b01);
        look();
        chk("rmt_regrant", {m_req, m_addr}, {1'b1, 32'h0000_0080});
        look();
        chk("rmt_ack", i_ack, 1'b1);
        tick();
        i_req = 1'b0;
        look();
        chk("rmt_idle", m_req, 1'b0);

        // Contention from a fresh reset (last-grant flag back to fetch).
        reset_check("reset_again");
        slave_echo = 1'b1;
        i_addr = 32'h0000_0200; d_addr = 32'h0000_0300; d_we = 1'b0; d_sel = 4'hF;
`ifdef ARB_ROUND_ROBIN_EN
        expect_resp(1'b1, 32'hFFFF_0300, 1'b0);
        expect_resp(1'b0, 32'hFFFF_0200, 1'b0);
        expect_resp(1'b1, 32'hFFFF_0300, 1'b0);
        expect_resp(1'b0, 32'hFFFF_0200, 1'b0);
`else
        for (int n = 0; n < 4; n++) expect_resp(1'b1, 32'hFFFF_0300, 1'b0);
`endif
        tick();
        i_req = 1'b1; d_req = 1'b1;
        acks = 0;
        for (int c = 0; c < 40 && acks < 4; c++) begin
            look();
            if (i_ack || d_ack) acks++;
        end
        chk("contention_acks", acks, 4);
        tick();
        i_req = 1'b0; d_req = 1'b0;
        look();
        chk("contention_idle", m_req, 1'b0);
        repeat (3) look();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
